tlul_socket_m1: RTL

M-to-1 TL-UL request arbiter feeding the device port of the bus fabric; it merges several host A channels onto one device A channel and routes device D-channel responses back to the originating host. Host identity is carried in extra upper bits of the device-side source ID. Per-host outstanding-request limits are supplied through a packed nibble vector parameter, matching the fabric's packed per-port configuration style.

---
 rtl/tlul_socket_m1_if.sv | 55 +++++
 rtl/tlul_socket_m1.sv | 105 ++++++++++
 2 files changed

// File: rtl/tlul_socket_m1_if.sv
// tlul_socket_m1_if: host-side and device-side TL-UL signal bundle for the M-to-1 socket
// slave modport: the socket's view. master modport: the hosts plus device driving it.
interface tlul_socket_m1_if #(
  parameter int M = 3,
  parameter int SrcW = 6
);
  localparam int IdW = $clog2(M);
  logic [M-1:0]        host_a_valid_i;
  logic [M-1:0]        host_a_ready_o;
  logic [3*M-1:0]      host_a_opcode_i;
  logic [32*M-1:0]     host_a_address_i;
  logic [32*M-1:0]     host_a_data_i;
  logic [SrcW*M-1:0]   host_a_source_i;
  logic [M-1:0]        host_d_valid_o;
  logic [M-1:0]        host_d_ready_i;
  logic [2:0]          host_d_opcode_o;
  logic [31:0]         host_d_data_o;
  logic [SrcW-1:0]     host_d_source_o;
  logic                host_d_error_o;
  logic                dev_a_valid_o;
  logic                dev_a_ready_i;
  logic [2:0]          dev_a_opcode_o;
  logic [31:0]         dev_a_address_o;
  logic [31:0]         dev_a_data_o;
  logic [SrcW+IdW-1:0] dev_a_source_o;
  logic                dev_d_valid_i;
  logic                dev_d_ready_o;
  logic [2:0]          dev_d_opcode_i;
  logic [31:0]         dev_d_data_i;
  logic                dev_d_error_i;
  logic [SrcW+IdW-1:0] dev_d_source_i;
  logic                unroutable_o;
  modport slave (
    input  host_a_valid_i, host_a_opcode_i, host_a_address_i, host_a_data_i, host_a_source_i,
    output host_a_ready_o,
    output host_d_valid_o, host_d_opcode_o, host_d_data_o, host_d_source_o, host_d_error_o,
    input  host_d_ready_i,
    output dev_a_valid_o, dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_source_o,
    input  dev_a_ready_i,
    input  dev_d_valid_i, dev_d_opcode_i, dev_d_data_i, dev_d_error_i, dev_d_source_i,
    output dev_d_ready_o,
    output unroutable_o
  );
  modport master (
    output host_a_valid_i, host_a_opcode_i, host_a_address_i, host_a_data_i, host_a_source_i,
    input  host_a_ready_o,
    input  host_d_valid_o, host_d_opcode_o, host_d_data_o, host_d_source_o, host_d_error_o,
    output host_d_ready_i,
    input  dev_a_valid_o, dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_source_o,
    output dev_a_ready_i,
    output dev_d_valid_i, dev_d_opcode_i, dev_d_data_i, dev_d_error_i, dev_d_source_i,
    input  dev_d_ready_o,
    input  unroutable_o
  );
endinterface

// File: rtl/tlul_socket_m1.sv
// tlul_socket_m1: round-robin M-to-1 TL-UL request arbiter with per-host outstanding limits and D-channel routing
// Ports: clk_i clock, rst_ni async active-low reset, bus (slave modport) carrying host A/D, device A/D and unroutable_o.
module tlul_socket_m1 #(
  parameter int M = 3,
  parameter int SrcW = 6,
  parameter logic [4*M-1:0] HMaxOut = 12'h442
) (
  input logic clk_i,
  input logic rst_ni,
  tlul_socket_m1_if.slave bus
);
  localparam int IdW = $clog2(M);
  logic [3:0] outCnt [M];
  logic [3:0] limit [M];
  logic [M-1:0] elig, inc, dec;
  logic [IdW-1:0] rrPtr, lockIdx, win, grantIdx, dIdx;
  logic [SrcW-1:0] srcSel;
  logic lockQ, found, aValid, aAcc, dRoutable, dAcc, unroutableQ;
  for (genvar g = 0; g < M; g++) begin : gElig
    assign limit[g] = (HMaxOut[4*g+:4] == 4'd0) ? 4'd1 : HMaxOut[4*g+:4];
    assign elig[g] = bus.host_a_valid_i[g] && (outCnt[g] < limit[g]);
  end
  // first eligible host at or after rrPtr, wrapping
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    win = rrPtr;
    for (int i = 0; i < M; i++) begin
      j = int'(rrPtr) + i;
      j = (j >= M) ? j - M : j;
      if (!found && elig[j]) begin
        found = 1'b1;
        win = IdW'(j);
      end
    end
  end
  // a stalled request keeps its grant so dev_a_* stay stable until accepted
  assign grantIdx = lockQ ? lockIdx : win;
  assign aValid = lockQ ? bus.host_a_valid_i[lockIdx] : found;
  assign aAcc = aValid && bus.dev_a_ready_i;
  always_comb begin
    bus.dev_a_opcode_o = bus.host_a_opcode_i[2:0];
    bus.dev_a_address_o = bus.host_a_address_i[31:0];
    bus.dev_a_data_o = bus.host_a_data_i[31:0];
    srcSel = bus.host_a_source_i[SrcW-1:0];
    bus.host_a_ready_o = '0;
    for (int h = 0; h < M; h++) begin
      if (grantIdx == IdW'(h)) begin
        bus.dev_a_opcode_o = bus.host_a_opcode_i[3*h+:3];
        bus.dev_a_address_o = bus.host_a_address_i[32*h+:32];
        bus.dev_a_data_o = bus.host_a_data_i[32*h+:32];
        srcSel = bus.host_a_source_i[SrcW*h+:SrcW];
        bus.host_a_ready_o[h] = bus.dev_a_ready_i && aValid;
      end
    end
  end
  assign bus.dev_a_valid_o = aValid;
  assign bus.dev_a_source_o = {grantIdx, srcSel};
  assign dIdx = bus.dev_d_source_i[SrcW+:IdW];
  assign dRoutable = int'(dIdx) < M;
  // responses for a nonexistent host are sunk so the device never stalls
  always_comb begin
    bus.host_d_valid_o = '0;
    bus.dev_d_ready_o = !dRoutable;
    for (int h = 0; h < M; h++) begin
      if (dIdx == IdW'(h)) begin
        bus.host_d_valid_o[h] = bus.dev_d_valid_i;
        bus.dev_d_ready_o = bus.host_d_ready_i[h];
      end
    end
  end
  assign dAcc = bus.dev_d_valid_i && bus.dev_d_ready_o;
  assign bus.host_d_opcode_o = bus.dev_d_opcode_i;
  assign bus.host_d_data_o = bus.dev_d_data_i;
  assign bus.host_d_error_o = bus.dev_d_error_i;
  assign bus.host_d_source_o = bus.dev_d_source_i[SrcW-1:0];
  assign bus.unroutable_o = unroutableQ;
  always_comb begin
    inc = '0;
    dec = '0;
    for (int h = 0; h < M; h++) begin
      inc[h] = aAcc && (grantIdx == IdW'(h));
      dec[h] = dAcc && (dIdx == IdW'(h));
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rrPtr <= '0;
      lockQ <= 1'b0;
      lockIdx <= '0;
      unroutableQ <= 1'b0;
      for (int h = 0; h < M; h++) outCnt[h] <= 4'd0;
    end else begin
      lockQ <= aValid && !bus.dev_a_ready_i;
      lockIdx <= grantIdx;
      if (aAcc) rrPtr <= (grantIdx == IdW'(M-1)) ? '0 : grantIdx + 1'b1;
      unroutableQ <= bus.dev_d_valid_i && !dRoutable;
      for (int h = 0; h < M; h++) begin
        if (inc[h] && !dec[h]) outCnt[h] <= outCnt[h] + 4'd1;
        else if (!inc[h] && dec[h] && outCnt[h] != 4'd0) outCnt[h] <= outCnt[h] - 4'd1;
      end
    end
  end
endmodule
